// File: rtl/alu_mdu_if.sv
// Operand/result handshake bundle for alu_mdu.
// The master side issues ops and consumes results; the slave side is the unit.
interface alu_mdu_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/alu_mdu.sv
// Single-cycle base ALU plus multiply/divide with shift-add and restoring-divide datapaths.
// One op in flight: accept in IDLE, result held in DONE until the consumer takes it.
module alu_mdu #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned FAST_MUL = 0
) (
    input logic      clk,
    input logic      rst,
    alu_mdu_if.slave bus
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;

    localparam logic [4:0] OpAdd    = 5'h00;
    localparam logic [4:0] OpSub    = 5'h01;
    localparam logic [4:0] OpAnd    = 5'h02;
    localparam logic [4:0] OpOr     = 5'h03;
    localparam logic [4:0] OpXor    = 5'h04;
    localparam logic [4:0] OpSlt    = 5'h05;
    localparam logic [4:0] OpSltu   = 5'h06;
    localparam logic [4:0] OpSll    = 5'h07;
    localparam logic [4:0] OpSrl    = 5'h08;
    localparam logic [4:0] OpSra    = 5'h09;
    localparam logic [4:0] OpPassB  = 5'h0A;
    localparam logic [4:0] OpMul    = 5'h10;
    localparam logic [4:0] OpMulh   = 5'h11;
    localparam logic [4:0] OpMulhsu = 5'h12;
    localparam logic [4:0] OpDiv    = 5'h14;
    localparam logic [4:0] OpRem    = 5'h16;

    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LastIt = CW'(XLEN - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;

    logic            is_mul, is_div, is_rem;
    logic            sgn_a, sgn_b, a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, alu_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, fast_prod;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic              last;

    // Signs applied to the magnitude product; MUL keeps the low half, MULH* the high half.
    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] mag, input logic neg,
                                                 input logic [4:0] op);
        logic [2*XLEN-1:0] p;
        p = neg ? -mag : mag;
        return (op == OpMul) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    always_comb begin
        is_mul   = bus.op[4:2] == 3'b100;
        is_div   = bus.op[4:2] == 3'b101;
        is_rem   = bus.op[1];
        sgn_a    = (bus.op == OpMulh) || (bus.op == OpMulhsu) ||
                   (bus.op == OpDiv) || (bus.op == OpRem);
        sgn_b    = (bus.op == OpMulh) || (bus.op == OpDiv) || (bus.op == OpRem);
        a_neg    = sgn_a && bus.a[XLEN-1];
        b_neg    = sgn_b && bus.b[XLEN-1];
        a_mag    = a_neg ? -bus.a : bus.a;
        b_mag    = b_neg ? -bus.b : bus.b;
        div_zero = bus.b == '0;
        div_ovf  = sgn_b && (bus.a == IntMin) && (bus.b == '1);
    end

    always_comb begin
        alu_res = '0;
        case (bus.op)
            OpAdd:   alu_res = bus.a + bus.b;
            OpSub:   alu_res = bus.a - bus.b;
            OpAnd:   alu_res = bus.a & bus.b;
            OpOr:    alu_res = bus.a | bus.b;
            OpXor:   alu_res = bus.a ^ bus.b;
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            OpSll:   alu_res = bus.a << bus.b[SHW-1:0];
            OpSrl:   alu_res = bus.a >> bus.b[SHW-1:0];
            OpSra:   alu_res = $unsigned($signed(bus.a) >>> bus.b[SHW-1:0]);
            OpPassB: alu_res = bus.b;
            default: alu_res = '0;
        endcase
    end

    // hi:lo is the running product (multiplier shifts out of lo) or remainder:quotient.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, lo_q[XLEN-1:1]};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = !div_diff[XLEN];
        fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
        last      = cnt_q == LastIt;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    op_d  = bus.op;
                    cnt_d = '0;
                    if (is_mul) begin
                        if (FAST_MUL != 0) begin
                            result_d = mul_pick(fast_prod, a_neg ^ b_neg, bus.op);
                            state_d  = StDone;
                        end else begin
                            hi_d    = '0;
                            lo_d    = b_mag;
                            opnd_d  = a_mag;
                            neg_d   = a_neg ^ b_neg;
                            state_d = StMul;
                        end
                    end else if (is_div) begin
                        if (div_zero) begin
                            result_d = is_rem ? bus.a : '1;
                            state_d  = StDone;
                        end else if (div_ovf) begin
                            result_d = is_rem ? '0 : IntMin;
                            state_d  = StDone;
                        end else begin
                            hi_d    = '0;
                            lo_d    = a_mag;
                            opnd_d  = b_mag;
                            neg_d   = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            state_d = StDiv;
                        end
                    end else begin
                        result_d = alu_res;
                        state_d  = StDone;
                    end
                end
            end
            StMul: begin
                {hi_d, lo_d} = mul_next;
                cnt_d        = cnt_q + 1'b1;
                if (last) begin
                    result_d = mul_pick(mul_next, neg_q, op_q);
                    cnt_d    = '0;
                    state_d  = StDone;
                end
            end
            StDiv: begin
                hi_d  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    if (op_q[1]) begin
                        result_d = rneg_q ? -hi_d : hi_d;
                    end else begin
                        result_d = neg_q ? -lo_d : lo_d;
                    end
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            result_q <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign bus.in_ready  = state_q == StIdle;
    assign bus.out_valid = state_q == StDone;
    assign bus.busy      = (state_q == StMul) || (state_q == StDiv);
    assign bus.result    = result_q;
endmodule
